sobel_edge_param: RTL

SOBEL_EDGE_PARAM -- requirements
Module: sobel_edge_param

---
 rtl/sobel_edge_param.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sobel_edge_param.sv
// sobel_edge_param: streaming 3x3 Sobel edge detector over a raster pixel stream.
// Two line buffers feed a 3x3 window; gradients are computed and reduced to
// one output pixel per input pixel with a fixed two-cycle latency.
// Ports:
//   iCLK, iRST         clock, asynchronous active-high reset
//   iGray, iDVAL, iSOF input pixel, valid, start-of-frame marker
//   iMODE, iTHRESH     output selection and threshold (quasi-static)
//   oEdge, oDVAL, oEOF result pixel, valid, last pixel of frame
module sobel_edge_param #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iGray,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic [1:0]        iMODE,
    input  logic [DATA_W+1:0] iTHRESH,
    output logic [DATA_W-1:0] oEdge,
    output logic              oDVAL,
    output logic              oEOF
);
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned SUM_W = DATA_W + 3;
    localparam int unsigned ABS_W = DATA_W + 2;
    localparam logic [DATA_W-1:0] MAX_PIX = '1;

    logic [COL_W-1:0]  colCnt, curCol, nextCol;
    logic [ROW_W-1:0]  rowCnt, curRow, nextRow;
    logic [DATA_W-1:0] lineBuf1 [IMG_W];
    logic [DATA_W-1:0] lineBuf2 [IMG_W];
    logic [DATA_W-1:0] win [3][3];
    logic              valid1, mask1, eof1;

    // Position of the current pixel; iSOF overrides the running counters.
    always_comb begin
        curCol  = iSOF ? '0 : colCnt;
        curRow  = iSOF ? '0 : rowCnt;
        nextCol = curCol + COL_W'(1);
        nextRow = curRow;
        if (curCol == COL_W'(IMG_W - 1)) begin
            nextCol = '0;
            nextRow = (curRow == ROW_W'(IMG_H - 1)) ? '0 : curRow + ROW_W'(1);
        end
    end

    // Line buffers: contents need no reset, border masking hides stale data.
    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            lineBuf1[curCol] <= iGray;
            lineBuf2[curCol] <= lineBuf1[curCol];
        end
    end

    // Stage 1: counters, window shift and per-pixel side information.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            colCnt <= '0;
            rowCnt <= '0;
            valid1 <= 1'b0;
            mask1  <= 1'b0;
            eof1   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            valid1 <= iDVAL;
            if (iDVAL) begin
                colCnt <= nextCol;
                rowCnt <= nextRow;
                mask1  <= (curRow < ROW_W'(2)) || (curCol < COL_W'(2));
                eof1   <= (curRow == ROW_W'(IMG_H - 1)) && (curCol == COL_W'(IMG_W - 1));
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lineBuf2[curCol];
                win[1][2] <= lineBuf1[curCol];
                win[2][2] <= iGray;
            end
        end
    end

    logic signed [SUM_W-1:0] pix [3][3];
    logic signed [SUM_W-1:0] gx, gy;
    logic [ABS_W-1:0]        absGx, absGy;
    logic [SUM_W-1:0]        mag;
    logic [DATA_W-1:0]       edgeC;

    // Stage 2 datapath: signed Sobel gradients, magnitudes and mode select.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pix[r][c] = $signed(SUM_W'(win[r][c]));
            end
        end
        gx = (pix[0][2] + (pix[1][2] <<< 1) + pix[2][2])
           - (pix[0][0] + (pix[1][0] <<< 1) + pix[2][0]);
        gy = (pix[2][0] + (pix[2][1] <<< 1) + pix[2][2])
           - (pix[0][0] + (pix[0][1] <<< 1) + pix[0][2]);
        absGx = gx[SUM_W-1] ? ABS_W'(-gx) : ABS_W'(gx);
        absGy = gy[SUM_W-1] ? ABS_W'(-gy) : ABS_W'(gy);
        mag   = SUM_W'(absGx) + SUM_W'(absGy);
        case (iMODE)
            2'd0:    edgeC = (mag[SUM_W-1:DATA_W] != '0) ? MAX_PIX : mag[DATA_W-1:0];
            2'd1:    edgeC = (mag >= SUM_W'(iTHRESH)) ? MAX_PIX : '0;
            2'd2:    edgeC = (absGx[ABS_W-1:DATA_W] != '0) ? MAX_PIX : absGx[DATA_W-1:0];
            default: edgeC = (absGy[ABS_W-1:DATA_W] != '0) ? MAX_PIX : absGy[DATA_W-1:0];
        endcase
    end

    // Output register with border masking.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oEdge <= '0;
            oDVAL <= 1'b0;
            oEOF  <= 1'b0;
        end else begin
            oDVAL <= valid1;
            oEOF  <= valid1 && eof1;
            if (valid1) begin
                oEdge <= mask1 ? '0 : edgeC;
            end
        end
    end
endmodule
